// File: rtl/lsb_embedder_if.sv
`default_nettype none
// ============================================================================
// Module   : lsb_embedder_if
// Brief    : FIFO-side bus of the LSB embedder (cover, message and stego FIFOs)
// Revision : 1.0 - initial release
// ============================================================================
interface lsb_embedder_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  pix_rden;
    logic [DATA_WIDTH-1:0] pix_dout;
    logic                  pix_empty;
    logic                  msg_rden;
    logic [7:0]            msg_dout;
    logic                  msg_empty;
    logic                  out_wren;
    logic [DATA_WIDTH-1:0] out_din;
    logic                  out_full;

    modport master (
        output pix_rden, msg_rden, out_wren, out_din,
        input  pix_dout, pix_empty, msg_dout, msg_empty, out_full
    );

    modport slave (
        input  pix_rden, msg_rden, out_wren, out_din,
        output pix_dout, pix_empty, msg_dout, msg_empty, out_full
    );
endinterface
`default_nettype wire

// File: rtl/lsb_embedder.sv
`default_nettype none
// ============================================================================
// Module   : lsb_embedder
// Brief    : Replaces pixel LSBs with message bits, MSB-first. Optional 16-bit
//            length header enabled by macro LSB_EMB_HDR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lsb_embedder #(
    parameter int DATA_WIDTH   = 8,
    parameter int BITS_PER_PIX = 1,
    parameter int LEN_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    output logic             busy,
    output logic             done,
    lsb_embedder_if.master   bus
);
    localparam int c_CHUNKS = 8 / BITS_PER_PIX;
    localparam int c_CW     = 4;
    localparam int c_BW     = LEN_W + 1;
`ifdef LSB_EMB_HDR_EN
    localparam int c_HDR_BYTES = 2;
`else
    localparam int c_HDR_BYTES = 0;
`endif

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LD_MSG  = 3'd1;
    localparam logic [2:0] c_CAP_MSG = 3'd2;
    localparam logic [2:0] c_LD_PIX  = 3'd3;
    localparam logic [2:0] c_CAP_PIX = 3'd4;
    localparam logic [2:0] c_WR      = 3'd5;
    localparam logic [2:0] c_DONE    = 3'd6;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [c_BW-1:0]       r_byte_cnt;
    logic [c_CW-1:0]       r_chunk;
    logic [7:0]            r_shreg;
    logic [DATA_WIDTH-1:0] r_out_din;
    logic [c_BW-1:0]       w_total;
    logic                  w_cur_hdr;
    logic [7:0]            w_cap_byte;
    logic                  w_pix_rden;
    logic                  w_msg_rden;
    logic                  w_out_wren;
    logic                  w_unused;

    // Byte counter holds the bytes still to embed, including the current one.
    assign w_total = {1'b0, msg_len} + c_BW'(c_HDR_BYTES);

`ifdef LSB_EMB_HDR_EN
    logic [LEN_W-1:0] r_len;
    logic [15:0]      w_hdr;
    logic [7:0]       w_hdr_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;
        end else if (r_state == c_IDLE && start) begin
            r_len <= msg_len;
        end
    end

    // While more bytes remain than the payload holds, we are still in the header.
    assign w_hdr      = 16'(r_len);
    assign w_cur_hdr  = (r_byte_cnt > {1'b0, r_len});
    assign w_hdr_byte = (r_byte_cnt == ({1'b0, r_len} + c_BW'(2))) ? w_hdr[15:8] : w_hdr[7:0];
    assign w_cap_byte = w_cur_hdr ? w_hdr_byte : bus.msg_dout;
`else
    assign w_cur_hdr  = 1'b0;
    assign w_cap_byte = bus.msg_dout;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next = (w_total == '0) ? c_DONE : c_LD_MSG;
                end
            end
            c_LD_MSG: begin
                if (w_cur_hdr || w_msg_rden) begin
                    w_next = c_CAP_MSG;
                end
            end
            c_CAP_MSG: w_next = c_LD_PIX;
            c_LD_PIX: begin
                if (w_pix_rden) begin
                    w_next = c_CAP_PIX;
                end
            end
            c_CAP_PIX: w_next = c_WR;
            c_WR: begin
                if (w_out_wren) begin
                    if (r_chunk > c_CW'(1)) begin
                        w_next = c_LD_PIX;
                    end else if (r_byte_cnt > c_BW'(1)) begin
                        w_next = c_LD_MSG;
                    end else begin
                        w_next = c_DONE;
                    end
                end
            end
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != c_IDLE);
        done       = 1'b0;
        w_pix_rden = 1'b0;
        w_msg_rden = 1'b0;
        w_out_wren = 1'b0;
        case (r_state)
            c_LD_MSG: w_msg_rden = !w_cur_hdr && !bus.msg_empty;
            c_LD_PIX: w_pix_rden = !bus.pix_empty;
            c_WR:     w_out_wren = !bus.out_full;
            c_DONE:   done       = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
            r_chunk    <= '0;
            r_shreg    <= '0;
            r_out_din  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_byte_cnt <= w_total;
                    end
                end
                c_CAP_MSG: begin
                    r_shreg <= w_cap_byte;
                    r_chunk <= c_CW'(c_CHUNKS);
                end
                c_CAP_PIX: begin
                    r_out_din <= {bus.pix_dout[DATA_WIDTH-1:BITS_PER_PIX],
                                  r_shreg[7:8-BITS_PER_PIX]};
                end
                c_WR: begin
                    if (w_out_wren) begin
                        r_shreg <= r_shreg << BITS_PER_PIX;
                        r_chunk <= r_chunk - c_CW'(1);
                        if (r_chunk == c_CW'(1) && r_byte_cnt > c_BW'(1)) begin
                            r_byte_cnt <= r_byte_cnt - c_BW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The replaced cover bits are intentionally discarded.
    assign w_unused = ^bus.pix_dout[BITS_PER_PIX-1:0];

    assign bus.pix_rden = w_pix_rden;
    assign bus.msg_rden = w_msg_rden;
    assign bus.out_wren = w_out_wren;
    assign bus.out_din  = r_out_din;
endmodule
`default_nettype wire

// File: tb/tb_lsb_embedder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsb_embedder
// Brief    : Directed self-checking bench; three embedders (1/2/4 bits per
//            pixel) share one FIFO model selected by sel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsb_embedder;
    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic [15:0] msg_len = '0;
    logic [1:0]  sel     = 2'd0;

    always #5 clk = ~clk;

    logic [2:0] busy_v, done_v, pix_rden_v, msg_rden_v, out_wren_v;
    logic [7:0] out_din_v [3];

    logic [7:0] pix_dout = '0;
    logic [7:0] msg_dout = '0;
    logic [7:0] pix_val  = '0;
    logic       full_hold = 1'b0;
    logic [7:0] msg_mem [64];
    logic [7:0] out_q [256];
    int pix_reads = 0, pix_limit = 0, msg_reads = 0, msg_limit = 0;
    int out_n = 0, done_cnt = 0, viol = 0, cyc = 0, last_wr_cyc = 0, done_cyc = 0;
    int n_cmp = 0, n_err = 0;

    wire pix_empty = (pix_reads >= pix_limit);
    wire msg_empty = (msg_reads >= msg_limit);

    for (genvar g = 0; g < 3; g++) begin : g_dut
        lsb_embedder_if #(.DATA_WIDTH(8)) bus ();
        assign bus.pix_dout  = pix_dout;
        assign bus.pix_empty = (sel != g) || pix_empty;
        assign bus.msg_dout  = msg_dout;
        assign bus.msg_empty = (sel != g) || msg_empty;
        assign bus.out_full  = (sel != g) || full_hold;
        assign pix_rden_v[g] = bus.pix_rden;
        assign msg_rden_v[g] = bus.msg_rden;
        assign out_wren_v[g] = bus.out_wren;
        assign out_din_v[g]  = bus.out_din;

        lsb_embedder #(.DATA_WIDTH(8), .BITS_PER_PIX(1 << g), .LEN_W(16)) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start && (sel == g)),
            .msg_len (msg_len),
            .busy    (busy_v[g]),
            .done    (done_v[g]),
            .bus     (bus.master)
        );
    end

    wire       w_pix_rden = pix_rden_v[sel];
    wire       w_msg_rden = msg_rden_v[sel];
    wire       w_out_wren = out_wren_v[sel];
    wire       w_done     = done_v[sel];
    wire [7:0] w_out_din  = out_din_v[sel];

    // FIFO model: first-word-fall-through-free, data valid the cycle after a read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (w_pix_rden) begin
            pix_dout  <= pix_val;
            pix_reads <= pix_reads + 1;
        end
        if (w_msg_rden) begin
            msg_dout  <= msg_mem[msg_reads[5:0]];
            msg_reads <= msg_reads + 1;
        end
        if (w_out_wren) begin
            out_q[out_n[7:0]] <= w_out_din;
            out_n       <= out_n + 1;
            last_wr_cyc <= cyc;
        end
        if (w_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if ((w_pix_rden && pix_empty) || (w_msg_rden && msg_empty) || (w_out_wren && full_hold))
            viol <= viol + 1;
    end

    localparam logic [7:0] C_EXP1 [8] = '{8'hFF, 8'hFE, 8'hFF, 8'hFE, 8'hFE, 8'hFF, 8'hFE, 8'hFF};
    localparam logic [7:0] C_EXP2 [8] = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF3, 8'hF2, 8'hF1, 8'hF0};
    localparam logic [7:0] C_EXP3 [8] = '{8'h80, 8'h80, 8'h81, 8'h81, 8'h81, 8'h81, 8'h80, 8'h80};
    localparam logic [7:0] C_EXPH [8] = '{8'h50, 8'h50, 8'h50, 8'h51, 8'h53, 8'h5C, 8'h00, 8'h00};
    localparam logic [7:0] C_EXP0 [8] = '{8'h50, 8'h50, 8'h50, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00};

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int base, input logic [7:0] e [8], input int n);
        for (int k = 0; k < n; k++)
            check_value($sformatf("%s_px%0d", tag, k), 32'(out_q[(base + k) % 256]), 32'(e[k]));
    endtask

    task automatic wait_done(input string tag, input int cnt0);
        int k = 0;
        while (done_cnt == cnt0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == cnt0) check_value({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_out(input string tag, input int target);
        int k = 0;
        while (out_n < target && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (out_n < target) check_value({tag, "_timeout"}, 32'(out_n), 32'(target));
    endtask

    task automatic start_job(input logic [1:0] d, input logic [15:0] len);
        @(negedge clk);
        sel     = d;
        msg_len = len;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        msg_len = 16'hBEEF;
    endtask

    initial begin
        int b_o, b_p, b_m, d0, bad, k;

        repeat (2) @(negedge clk);
        check_value("rst_busy", 32'(busy_v), 0);
        check_value("rst_done", 32'(done_v), 0);
        check_value("rst_rden", 32'({pix_rden_v, msg_rden_v}), 0);
        check_value("rst_wren", 32'(out_wren_v), 0);
        check_value("rst_dout", 32'({out_din_v[0], out_din_v[1], out_din_v[2]}), 0);
        #2 rst_n = 1'b1;

`ifdef LSB_EMB_HDR_EN
        // Header + one payload byte, 4 bits per pixel.
        b_o = out_n; b_p = pix_reads; b_m = msg_reads; d0 = done_cnt;
        msg_mem[b_m % 64] = 8'h3C; msg_mem[(b_m + 1) % 64] = 8'h99;
        msg_limit = b_m + 2; pix_val = 8'h50; pix_limit = b_p + 10;
        start_job(2'd2, 16'd1);
        wait_done("hdr1", d0);
        check_seq("hdr1", b_o, C_EXPH, 6);
        check_value("hdr1_nout", 32'(out_n - b_o), 6);
        check_value("hdr1_msgrd", 32'(msg_reads - b_m), 1);
        check_value("hdr1_pixrd", 32'(pix_reads - b_p), 6);

        // Zero-length message still carries the header.
        b_o = out_n; b_p = pix_reads; b_m = msg_reads; d0 = done_cnt;
        pix_limit = b_p + 10;
        start_job(2'd2, 16'd0);
        wait_done("hdr0", d0);
        check_seq("hdr0", b_o, C_EXP0, 4);
        check_value("hdr0_nout", 32'(out_n - b_o), 4);
        check_value("hdr0_msgrd", 32'(msg_reads - b_m), 0);
        check_value("hdr0_busy", 32'(busy_v[2]), 0);
`else
        // 1 bit/pixel, 0xA5 into 0xFF pixels, with a start pulse while busy.
        b_o = out_n; b_p = pix_reads; b_m = msg_reads; d0 = done_cnt;
        msg_mem[b_m % 64] = 8'hA5; msg_mem[(b_m + 1) % 64] = 8'h77;
        msg_limit = b_m + 2; pix_val = 8'hFF; pix_limit = b_p + 12;
        start_job(2'd0, 16'd1);
        repeat (2) @(negedge clk);
        start = 1'b1; msg_len = 16'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("t1", d0);
        repeat (3) @(negedge clk);
        check_seq("t1", b_o, C_EXP1, 8);
        check_value("t1_nout", 32'(out_n - b_o), 8);
        check_value("t1_msgrd", 32'(msg_reads - b_m), 1);
        check_value("t1_pixrd", 32'(pix_reads - b_p), 8);
        check_value("t1_ndone", 32'(done_cnt - d0), 1);
        check_value("t1_done_lat", 32'(done_cyc - last_wr_cyc), 1);
        check_value("t1_busy", 32'(busy_v[0]), 0);

        // Zero-length job: DONE straight away, no FIFO traffic.
        b_o = out_n; b_p = pix_reads; b_m = msg_reads;
        start_job(2'd0, 16'd0);
        check_value("z_done_hi", 32'(done_v[0]), 1);
        check_value("z_busy_hi", 32'(busy_v[0]), 1);
        @(negedge clk);
        check_value("z_done_lo", 32'(done_v[0]), 0);
        check_value("z_busy_lo", 32'(busy_v[0]), 0);
        check_value("z_traffic", 32'((out_n - b_o) + (pix_reads - b_p) + (msg_reads - b_m)), 0);

        // Stalls: output full while in WR, then cover FIFO empty in LD_PIX.
        b_o = out_n; b_p = pix_reads; b_m = msg_reads; d0 = done_cnt;
        msg_mem[b_m % 64] = 8'h3C; msg_limit = b_m + 1;
        pix_val = 8'h81; pix_limit = b_p + 3; full_hold = 1'b1;
        start_job(2'd0, 16'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 5 && (out_wren_v[0] || out_din_v[0] != 8'h80)) bad++;
        end
        check_value("full_stall", 32'(bad), 0);
        check_value("full_nout", 32'(out_n - b_o), 0);
        full_hold = 1'b0;
        wait_out("pix_stall", b_o + 3);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (pix_rden_v[0] || out_din_v[0] != 8'h81) bad++;
        end
        check_value("pix_stall", 32'(bad), 0);
        check_value("pix_nout", 32'(out_n - b_o), 3);
        pix_limit = b_p + 8;
        wait_done("t3", d0);
        check_seq("t3", b_o, C_EXP3, 8);
        check_value("t3_pixrd", 32'(pix_reads - b_p), 8);

        // Asynchronous reset after the third write of a 2 bit/pixel job.
        b_o = out_n; b_p = pix_reads; b_m = msg_reads;
        msg_mem[b_m % 64] = 8'hFF; msg_limit = b_m + 1;
        pix_val = 8'h00; pix_limit = b_p + 4;
        start_job(2'd1, 16'd1);
        wait_out("arst", b_o + 3);
        check_value("arst_pre_dout", 32'(out_din_v[1]), 32'h03);
        #2 rst_n = 1'b0;
        #1;
        check_value("arst_busy", 32'(busy_v[1]), 0);
        check_value("arst_done", 32'(done_v[1]), 0);
        check_value("arst_en", 32'({pix_rden_v[1], msg_rden_v[1], out_wren_v[1]}), 0);
        check_value("arst_dout", 32'(out_din_v[1]), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Fresh 2 bit/pixel job after the abort.
        b_o = out_n; b_p = pix_reads; b_m = msg_reads; d0 = done_cnt;
        msg_mem[b_m % 64] = 8'h1B; msg_mem[(b_m + 1) % 64] = 8'hE4;
        msg_limit = b_m + 2; pix_val = 8'hF0; pix_limit = b_p + 8;
        start_job(2'd1, 16'd2);
        k = 0;
        while (!done_v[1] && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_value("t2_done_seen", 32'(done_v[1]), 1);
        check_value("t2_busy_in_done", 32'(busy_v[1]), 1);
        @(negedge clk);
        check_value("t2_busy_after", 32'(busy_v[1]), 0);
        check_value("t2_done_after", 32'(done_v[1]), 0);
        check_seq("t2", b_o, C_EXP2, 8);
        check_value("t2_nout", 32'(out_n - b_o), 8);
        check_value("t2_msgrd", 32'(msg_reads - b_m), 2);
        check_value("t2_pixrd", 32'(pix_reads - b_p), 8);
`endif
        repeat (2) @(negedge clk);
        check_value("flag_violations", 32'(viol), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
